// File: rtl/apb_uart_pkg.sv
// Shared types and helpers for the APB master arbiter in front of the APB UART slave.
package apb_uart_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Width of the ACCESS wait counter; a disabled timeout still gets a 1-bit counter.
    function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
        int unsigned w;
        if (cycles == 0) begin
            w = 1;
        end else begin
            w = 32'($clog2(cycles + 1));
        end
        return w;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester command/response ports plus the APB master bus, bundled for the arbiter.
interface apb_master_arbiter_if
    import apb_uart_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16
) ();

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;

    logic [ADDR_WIDTH-1:0]         PADDR;
    logic                          PSELx;
    logic                          PENABLE;
    logic                          PWRITE;
    logic [DATA_WIDTH-1:0]         PWDATA;
    logic                          PREADY;
    logic [DATA_WIDTH-1:0]         PRDATA;
    logic                          PSLVERR;

    logic                          grant_id;
    logic                          busy;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PADDR, PSELx, PENABLE, PWRITE, PWDATA,
        input  PREADY, PRDATA, PSLVERR,
        output grant_id, busy
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PADDR, PSELx, PENABLE, PWRITE, PWDATA,
        output PREADY, PRDATA, PSLVERR,
        input  grant_id, busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; a tie goes to the requester that did not win last.
module rr_arbiter2
    import apb_uart_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_id
);

    always_comb begin
        gnt    = '0;
        gnt_id = last_grant;
        case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last_grant;
            default: gnt_id = last_grant;
        endcase
        if (enable && (req != '0)) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters: round-robin accept, SETUP/ACCESS sequencing,
// PREADY wait states with optional timeout abort, and per-requester response pulses.
module apb_master_arbiter
    import apb_uart_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                  PCLK,
    input logic                  PRESETn,
    apb_master_arbiter_if.master bus
);

    localparam int unsigned      CNT_W   = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TMO_EN  = (TIMEOUT_CYCLES != 0);

    apb_state_e              state_q, state_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    grant_id_q, grant_id_d;
    logic                    last_grant_q, last_grant_d;
    logic                    busy_q, busy_d;
    logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;

    logic                    timeout_c;
    logic                    complete_c;
    logic                    accept_en_c;
    logic [NUM_REQ-1:0]      gnt_c;
    logic                    gnt_id_c;
    logic                    any_gnt_c;

    assign timeout_c   = TMO_EN && (wait_cnt_q == TMO_VAL);
    assign complete_c  = (state_q == ST_ACCESS) && (bus.PREADY || timeout_c);
    assign accept_en_c = (state_q == ST_IDLE) || complete_c;
    assign any_gnt_c   = |gnt_c;

    rr_arbiter2 u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .enable     (accept_en_c),
        .gnt        (gnt_c),
        .gnt_id     (gnt_id_c)
    );

    always_comb begin
        state_d      = state_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (any_gnt_c) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                state_d    = ST_ACCESS;
                wait_cnt_d = '0;
            end
            ST_ACCESS: begin
                if (complete_c) begin
                    state_d = any_gnt_c ? ST_SETUP : ST_IDLE;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Response goes to the owner of the finishing transfer, before any new grant lands.
        if (complete_c) begin
            rsp_valid_d[grant_id_q] = 1'b1;
            rsp_rdata_d = bus.PREADY ? bus.PRDATA : '0;
            rsp_err_d   = bus.PREADY ? bus.PSLVERR : 1'b1;
        end

        if (any_gnt_c) begin
            grant_id_d   = gnt_id_c;
            last_grant_d = gnt_id_c;
            pwrite_d     = bus.req_write[gnt_id_c];
            paddr_d      = gnt_id_c ? bus.req_addr[2*ADDR_WIDTH-1 -: ADDR_WIDTH]
                                    : bus.req_addr[ADDR_WIDTH-1:0];
            pwdata_d     = gnt_id_c ? bus.req_wdata[2*DATA_WIDTH-1 -: DATA_WIDTH]
                                    : bus.req_wdata[DATA_WIDTH-1:0];
        end

        psel_d    = (state_d != ST_IDLE);
        penable_d = (state_d == ST_ACCESS);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= ST_IDLE;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign bus.req_ready = gnt_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PSELx     = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: transaction table plus tie, back-to-back and
// mid-transfer reset sequences, with the APB slave side driven by hand.
module tb_apb_master_arbiter;

    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 16;
    localparam int unsigned TMO = 4;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;

    int total = 0;
    int bad   = 0;

    apb_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

    apb_master_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bif)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        id;
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] wdata;
        int          waits;      // PREADY-low ACCESS cycles before ready (large = never)
        logic [15:0] prdata;
        logic        slverr;
        int          exp_len;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input logic [1:0] v, input logic [1:0] w,
                             input logic [3:0] a0, input logic [3:0] a1,
                             input logic [15:0] d0, input logic [15:0] d1);
        bif.req_valid = v;
        bif.req_write = w;
        bif.req_addr  = {a1, a0};
        bif.req_wdata = {d1, d0};
    endtask

    task automatic run_txn(input vec_t v, input int n);
        int acc;
        @(negedge PCLK);
        if (v.id) drive_req(2'b10, {v.wr, 1'b0}, 4'h0, v.addr, 16'h0, v.wdata);
        else      drive_req(2'b01, {1'b0, v.wr}, v.addr, 4'h0, v.wdata, 16'h0);
        bif.PREADY = 1'b0; bif.PSLVERR = 1'b0; bif.PRDATA = 16'hDEAD;
        #1 chk($sformatf("v%0d_ready", n), bif.req_ready, v.id ? 2'b10 : 2'b01);
        @(negedge PCLK);
        drive_req(2'b00, 2'b00, 4'h0, 4'h0, 16'h0, 16'h0);
        #1;
        chk($sformatf("v%0d_setup_sel_en", n), {bif.PSELx, bif.PENABLE, bif.busy}, 3'b101);
        chk($sformatf("v%0d_setup_cmd", n), {bif.PWRITE, bif.PADDR, bif.PWDATA}, {v.wr, v.addr, v.wdata});
        chk($sformatf("v%0d_grant", n), bif.grant_id, v.id);
        chk($sformatf("v%0d_setup_ready", n), bif.req_ready, 2'b00);
        acc = 0;
        @(negedge PCLK);
        while (bif.PENABLE === 1'b1 && acc < 40) begin
            acc++;
            bif.PREADY  = (acc == v.waits + 1);
            bif.PRDATA  = bif.PREADY ? v.prdata : 16'hDEAD;
            bif.PSLVERR = bif.PREADY ? v.slverr : 1'b0;
            #1;
            chk($sformatf("v%0d_acc%0d_stable", n, acc),
                {bif.PSELx, bif.PADDR, bif.PWDATA, bif.rsp_valid}, {1'b1, v.addr, v.wdata, 2'b00});
            @(negedge PCLK);
        end
        bif.PREADY = 1'b0; bif.PRDATA = 16'hDEAD; bif.PSLVERR = 1'b0;
        #1;
        chk($sformatf("v%0d_access_len", n), acc, v.exp_len);
        chk($sformatf("v%0d_rsp_valid", n), bif.rsp_valid, v.id ? 2'b10 : 2'b01);
        chk($sformatf("v%0d_rsp_rdata", n), bif.rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_rsp_err", n), bif.rsp_err, v.exp_err);
        @(negedge PCLK);
        #1;
        chk($sformatf("v%0d_idle", n), {bif.rsp_valid, bif.PSELx, bif.PENABLE, bif.busy}, 5'b0);
        chk($sformatf("v%0d_rdata_hold", n), bif.rsp_rdata, v.exp_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] t_rdy [9];
        logic [1:0] t_sp  [9];
        logic [3:0] t_adr [9];
        logic [1:0] t_rsp [9];

        //          id    wr    addr   wdata     waits prdata    err   len exp_rdata exp_err
        vecs[0] = '{1'b0, 1'b1, 4'h0, 16'h0041, 0,  16'h1234, 1'b0, 1, 16'h1234, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 4'h8, 16'h0000, 0,  16'h5A5A, 1'b0, 1, 16'h5A5A, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 4'h4, 16'h0000, 3,  16'hBEEF, 1'b0, 4, 16'hBEEF, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 4'h3, 16'hCAFE, 0,  16'h0000, 1'b1, 1, 16'h0000, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 4'hF, 16'h0000, 99, 16'h0000, 1'b0, 5, 16'h0000, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 4'h2, 16'h0000, 2,  16'h00FF, 1'b0, 3, 16'h00FF, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 4'h7, 16'hFFFF, 4,  16'h1111, 1'b0, 5, 16'h1111, 1'b0};

        // Tie sequence, one entry per cycle starting at the first accept.
        t_rdy = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        t_sp  = '{2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00};
        t_adr = '{4'h0,  4'h4,  4'h4,  4'h8,  4'h8,  4'h4,  4'h4,  4'h4,  4'h4};
        t_rsp = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};

        drive_req(2'b00, 2'b00, 4'h0, 4'h0, 16'h0, 16'h0);
        bif.PREADY = 1'b0; bif.PRDATA = 16'h0; bif.PSLVERR = 1'b0;
        #12;
        chk("reset_bus", {bif.PSELx, bif.PENABLE, bif.PWRITE, bif.PADDR, bif.PWDATA}, 23'b0);
        chk("reset_rsp", {bif.rsp_valid, bif.rsp_rdata, bif.rsp_err}, 19'b0);
        chk("reset_misc", {bif.grant_id, bif.busy}, 2'b00);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Repeated ties with PREADY high: req0, req1, req0 back to back.
        for (int c = 0; c < 9; c++) begin
            @(negedge PCLK);
            if (c < 5) drive_req(2'b11, 2'b00, 4'h4, 4'h8, 16'h0, 16'h0);
            else       drive_req(2'b00, 2'b00, 4'h0, 4'h0, 16'h0, 16'h0);
            bif.PREADY = 1'b1;
            bif.PRDATA = 16'h0;
            #1;
            chk($sformatf("tie_c%0d_ready", c), bif.req_ready, t_rdy[c]);
            chk($sformatf("tie_c%0d_sel_en", c), {bif.PSELx, bif.PENABLE}, t_sp[c]);
            chk($sformatf("tie_c%0d_paddr", c), bif.PADDR, t_adr[c]);
            chk($sformatf("tie_c%0d_rsp", c), bif.rsp_valid, t_rsp[c]);
        end
        bif.PREADY = 1'b0;

        for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

        // Reset during ACCESS of a req0 read; last_grant is 0 going in.
        @(negedge PCLK);
        drive_req(2'b01, 2'b00, 4'h5, 4'h0, 16'h0, 16'h0);
        bif.PREADY = 1'b0;
        @(negedge PCLK);
        drive_req(2'b00, 2'b00, 4'h0, 4'h0, 16'h0, 16'h0);
        @(negedge PCLK);
        #1 chk("rst_pre_access", {bif.PSELx, bif.PENABLE}, 2'b11);
        #2 PRESETn = 1'b0;
        #1 chk("rst_async_drop", {bif.PSELx, bif.PENABLE, bif.busy, bif.rsp_valid}, 5'b0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge PCLK);
            #1 chk($sformatf("rst_quiet_c%0d", c), {bif.rsp_valid, bif.PSELx}, 3'b0);
        end
        @(negedge PCLK);
        drive_req(2'b11, 2'b00, 4'h4, 4'h8, 16'h0, 16'h0);
        bif.PREADY = 1'b1;
        #1 chk("rst_tie_ready", bif.req_ready, 2'b01);
        @(negedge PCLK);
        drive_req(2'b00, 2'b00, 4'h0, 4'h0, 16'h0, 16'h0);
        #1 chk("rst_tie_grant", {bif.grant_id, bif.PADDR}, {1'b0, 4'h4});
        repeat (4) @(negedge PCLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
